// File: rtl/bsg_credit_counter_multi_pkg.sv
// Shared sizing helpers for the multi-channel credit counter.
// The sender logic and the bench use them as well.
package bsg_credit_counter_multi_pkg;

  function automatic int cnt_width_f(int max_tokens, int lg_decim, int margin);
    return margin + $clog2(max_tokens + 1) + lg_decim;
  endfunction

  function automatic int cap_f(int max_tokens, int lg_decim, int margin);
    return (max_tokens << lg_decim) << margin;
  endfunction

  function automatic int token_worth_f(int lg_decim);
    return 1 << lg_decim;
  endfunction

endpackage

// File: rtl/bsg_credit_counter_channel.sv
// One credit channel: it holds the token-return delay line, the credit counter,
// the accept check and the sticky overflow/underflow flags.
module bsg_credit_counter_channel
  import bsg_credit_counter_multi_pkg::*;
#(
  parameter int max_tokens_p                    = 4,
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int extra_margin_p                  = 0,
  parameter int start_full_p                    = 1,
  parameter int lg_max_dec_p                    = 0,
  parameter int check_excess_credits_p          = 1,
  parameter int inc_latency_p                   = 0,
  localparam int cw_lp = cnt_width_f(max_tokens_p, lg_credit_to_token_decimation_p, extra_margin_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  inc_token_i,
  input  logic                  dec_v_i,
  input  logic [lg_max_dec_p:0] dec_credits_i,
  input  logic                  infinite_credits_i,
  output logic                  dec_ok_o,
  output logic                  credits_avail_o,
  output logic [cw_lp-1:0]      credits_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [cw_lp:0] cap_lp =
    (cw_lp+1)'(cap_f(max_tokens_p, lg_credit_to_token_decimation_p, extra_margin_p));
  localparam logic [cw_lp:0] tw_lp =
    (cw_lp+1)'(token_worth_f(lg_credit_to_token_decimation_p));
  localparam logic [cw_lp-1:0] rst_lp =
    (start_full_p != 0) ? cw_lp'(max_tokens_p << lg_credit_to_token_decimation_p) : '0;

  logic inc_d;

  if (inc_latency_p == 0) begin : g_nolat
    assign inc_d = inc_token_i;
  end else begin : g_lat
    // Cleared in reset so that tokens already in flight are dropped too.
    logic [inc_latency_p-1:0] inc_pipe_q;
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) inc_pipe_q <= '0;
      else            inc_pipe_q <= (inc_pipe_q << 1) | inc_latency_p'(inc_token_i);
    end
    assign inc_d = inc_pipe_q[inc_latency_p-1];
  end

  logic [cw_lp-1:0] credits_q, credits_d;
  logic             ov_q, ov_d, un_q, un_d;
  logic             fits, spend;
  logic [cw_lp:0]   sum;

  // The check looks at registered credits only; a same-cycle token never funds a spend.
  assign fits            = 32'(dec_credits_i) <= 32'(credits_q);
  assign dec_ok_o        = dec_v_i & (infinite_credits_i | fits);
  assign spend           = dec_ok_o & ~infinite_credits_i;
  assign credits_avail_o = infinite_credits_i | (credits_q != '0);

  always_comb begin
    sum       = {1'b0, credits_q} + (inc_d ? tw_lp : '0)
              - (spend ? (cw_lp+1)'(dec_credits_i) : '0);
    credits_d = sum[cw_lp-1:0];
    ov_d      = ov_q;
    if (check_excess_credits_p != 0 && sum > cap_lp) begin
      credits_d = cap_lp[cw_lp-1:0];
      ov_d      = 1'b1;
    end
    un_d      = un_q | (dec_v_i & ~dec_ok_o);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      credits_q <= rst_lp;
      ov_q      <= 1'b0;
      un_q      <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ov_q      <= ov_d;
      un_q      <= un_d;
    end
  end

  assign credits_o   = credits_q;
  assign overflow_o  = ov_q;
  assign underflow_o = un_q;

endmodule

// File: rtl/bsg_credit_counter_multi.sv
// Single-clock multi-channel credit counter: one independent channel per VC,
// and each channel's ports are sliced from flat vectors.
module bsg_credit_counter_multi
  import bsg_credit_counter_multi_pkg::*;
#(
  parameter int num_channels_p                  = 4,
  parameter int max_tokens_p                    = 4,
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int extra_margin_p                  = 0,
  parameter int start_full_p                    = 1,
  parameter int lg_max_dec_p                    = 0,
  parameter int check_excess_credits_p          = 1,
  parameter int inc_latency_p                   = 0,
  localparam int cw_lp = cnt_width_f(max_tokens_p, lg_credit_to_token_decimation_p, extra_margin_p),
  localparam int dw_lp = lg_max_dec_p + 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_channels_p-1:0]         inc_token_i,
  input  logic [num_channels_p-1:0]         dec_v_i,
  input  logic [num_channels_p*dw_lp-1:0]   dec_credits_i,
  input  logic [num_channels_p-1:0]         infinite_credits_i,
  output logic [num_channels_p-1:0]         dec_ok_o,
  output logic [num_channels_p-1:0]         credits_avail_o,
  output logic [num_channels_p*cw_lp-1:0]   credits_o,
  output logic [num_channels_p-1:0]         overflow_o,
  output logic [num_channels_p-1:0]         underflow_o
);

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    bsg_credit_counter_channel #(
      .max_tokens_p                   (max_tokens_p),
      .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p),
      .extra_margin_p                 (extra_margin_p),
      .start_full_p                   (start_full_p),
      .lg_max_dec_p                   (lg_max_dec_p),
      .check_excess_credits_p         (check_excess_credits_p),
      .inc_latency_p                  (inc_latency_p)
    ) u_ch (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .inc_token_i       (inc_token_i[c]),
      .dec_v_i           (dec_v_i[c]),
      .dec_credits_i     (dec_credits_i[c*dw_lp +: dw_lp]),
      .infinite_credits_i(infinite_credits_i[c]),
      .dec_ok_o          (dec_ok_o[c]),
      .credits_avail_o   (credits_avail_o[c]),
      .credits_o         (credits_o[c*cw_lp +: cw_lp]),
      .overflow_o        (overflow_o[c]),
      .underflow_o       (underflow_o[c])
    );
  end

endmodule
